// File: rtl/chan_mux_pkg.sv
// Shared types and sizing helpers for the channel multiplexer / scanner.
package chan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_e;

  // Channel-index width: at least one bit even for tiny channel counts.
  function automatic int sel_w_f(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/next_chan_pick.sv
// Combinational channel picker: lowest enabled channel, and the next enabled
// channel strictly above ptr with wrap-around (rotate + priority encode).
module next_chan_pick
  import chan_mux_pkg::*;
#(
  parameter int  NUM_CH = 8,
  localparam int SEL_W  = sel_w_f(NUM_CH)
) (
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  first,
  output logic [SEL_W-1:0]  next,
  output logic              none
);

  logic [2*NUM_CH-1:0] shifted;
  int                  start_idx;
  int                  off;

  // Rotating by ptr+1 lets a single enabled channel find itself at the top offset.
  always_comb begin
    none  = (ch_en == '0);
    first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      first = ch_en[i] ? SEL_W'(i) : first;
    end
    start_idx = (int'(ptr) + 1) % NUM_CH;
    shifted   = {ch_en, ch_en} >> start_idx;
    off       = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      off = shifted[k] ? k : off;
    end
    next = SEL_W'((start_idx + off) % NUM_CH);
  end

endmodule

// File: rtl/chan_mux_scan.sv
// N-channel registered multiplexer with a fixed-select pass-through mode and an
// auto-scan sequencer presenting settled samples on a valid/ready output.
module chan_mux_scan
  import chan_mux_pkg::*;
#(
  parameter int  NUM_CH  = 8,
  parameter int  DATA_W  = 1,
  parameter int  DWELL_W = 8,
  localparam int SEL_W   = sel_w_f(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic                     start,
  input  logic                     stop,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     sel_err
);

  state_e              state_q;
  logic [SEL_W-1:0]    ptr_q;
  logic [DWELL_W-1:0]  cnt_q;
  logic                stop_pend_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [SEL_W-1:0]    out_ch_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                sel_err_q;

  logic [SEL_W-1:0]    first_ch;
  logic [SEL_W-1:0]    next_ch;
  logic                no_ch;
  logic [DATA_W-1:0]   fixed_word;
  logic [DATA_W-1:0]   scan_word;
  logic                sel_ok;
  logic                xfer;

  next_chan_pick #(.NUM_CH(NUM_CH)) u_pick (
    .ch_en (ch_en),
    .ptr   (ptr_q),
    .first (first_ch),
    .next  (next_ch),
    .none  (no_ch)
  );

  // Explicit per-channel compare keeps out-of-range indices from reaching din.
  always_comb begin
    fixed_word = '0;
    scan_word  = '0;
    sel_ok     = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      fixed_word = (sel == SEL_W'(k))   ? din[k*DATA_W +: DATA_W] : fixed_word;
      scan_word  = (ptr_q == SEL_W'(k)) ? din[k*DATA_W +: DATA_W] : scan_word;
      sel_ok     = sel_ok | (sel == SEL_W'(k));
    end
    xfer = out_valid_q & out_ready;
  end

  // Mode/scan sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      sel_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!mode) begin
            if (!out_valid_q || out_ready) begin
              if (sel_ok) begin
                out_data_q  <= fixed_word;
                out_ch_q    <= sel;
                out_valid_q <= 1'b1;
              end else begin
                out_valid_q <= 1'b0;
                sel_err_q   <= 1'b1;
              end
            end
          end else begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
            end
            if (start && !no_ch) begin
              state_q     <= SETTLE;
              ptr_q       <= first_ch;
              cnt_q       <= dwell;
              stop_pend_q <= 1'b0;
              busy_q      <= 1'b1;
            end
          end
        end
        SETTLE: begin
          stop_pend_q <= stop_pend_q | stop;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
            if (out_ready) begin
              out_valid_q <= 1'b0;
            end
          end else if (!out_valid_q || out_ready) begin
            // A leftover fixed-mode word must drain before the scan sample replaces it.
            out_data_q  <= scan_word;
            out_ch_q    <= ptr_q;
            out_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            ptr_q       <= next_ch;
            if (stop_pend_q || stop || !mode || no_ch) begin
              state_q     <= IDLE;
              stop_pend_q <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              state_q <= SETTLE;
              cnt_q   <= dwell;
            end
          end else begin
            stop_pend_q <= stop_pend_q | stop;
          end
        end
        default: begin
          state_q     <= IDLE;
          stop_pend_q <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Self-checking bench for chan_mux_scan: an 8-channel instance for fixed and scan
// modes, and a 6-channel instance for out-of-range select.
module tb_chan_mux_scan;

  typedef struct packed {
    logic [2:0] ch;
    logic [3:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] din8;
  logic [7:0]  ch_en8;
  logic        mode8, start8, stop8, ready8;
  logic [2:0]  sel8;
  logic [7:0]  dwell8;
  logic [3:0]  data8;
  logic [2:0]  ch8;
  logic        valid8, busy8, err8;

  logic [23:0] din6;
  logic [5:0]  ch_en6;
  logic        mode6, start6, stop6, ready6;
  logic [2:0]  sel6;
  logic [7:0]  dwell6;
  logic [3:0]  data6;
  logic [2:0]  ch6;
  logic        valid6, busy6, err6;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  chan_mux_scan #(.NUM_CH(8), .DATA_W(4), .DWELL_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .ch_en(ch_en8), .mode(mode8), .sel(sel8),
    .dwell(dwell8), .start(start8), .stop(stop8), .out_data(data8), .out_ch(ch8),
    .out_valid(valid8), .out_ready(ready8), .busy(busy8), .sel_err(err8)
  );

  chan_mux_scan #(.NUM_CH(6), .DATA_W(4), .DWELL_W(8)) u6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .ch_en(ch_en6), .mode(mode6), .sel(sel6),
    .dwell(dwell6), .start(start6), .stop(stop6), .out_data(data6), .out_ch(ch6),
    .out_valid(valid6), .out_ready(ready6), .busy(busy6), .sel_err(err6)
  );

  always #5 clk = ~clk;

  // Channel k carries the value k+3.
  function automatic exp_t mk(input int ch);
    exp_t r;
    r.ch   = 3'(ch);
    r.data = 4'(ch + 3);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid8(input int budget);
    int n;
    n = 0;
    while (!valid8 && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (valid8 !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_valid: out_valid=%0b after %0d cycles, required 1", valid8, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({valid8, busy8, err8, data8, ch8} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset8: got v=%0b b=%0b e=%0b d=%0h c=%0d, required all 0",
               valid8, busy8, err8, data8, ch8);
    end
    n_checks++;
    if ({valid6, busy6, err6, data6, ch6} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset6: got v=%0b b=%0b e=%0b d=%0h c=%0d, required all 0",
               valid6, busy6, err6, data6, ch6);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fixed();
    mode8  = 1'b0;
    ready8 = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel8 = 3'(s);
      sb.push_back(mk(s));
      tick();
      n_checks++;
      if (err8 !== 1'b0) begin
        n_fail++;
        $display("FAIL fixed_sel_err: sel=%0d got %0b, required 0", s, err8);
      end
      if (valid8 && ready8) begin
        e = sb.pop_front();
        n_checks++;
        if ({ch8, data8} !== e) begin
          n_fail++;
          $display("FAIL fixed_word: sel=%0d got ch=%0d d=%0h, required ch=%0d d=%0h",
                   s, ch8, data8, e.ch, e.data);
        end
      end else begin
        n_checks++;
        n_fail++;
        $display("FAIL fixed_valid: sel=%0d got out_valid=%0b, required 1", s, valid8);
      end
    end
  endtask

  task automatic test_sel_err();
    mode6  = 1'b0;
    ready6 = 1'b1;
    sel6   = 3'd3;
    tick();
    n_checks++;
    if ({valid6, err6, data6} !== {1'b1, 1'b0, 4'd6}) begin
      n_fail++;
      $display("FAIL sel6_ok: got v=%0b e=%0b d=%0h, required v=1 e=0 d=6", valid6, err6, data6);
    end
    sel6 = 3'd7;
    tick();
    n_checks++;
    if ({valid6, err6, data6} !== {1'b0, 1'b1, 4'd6}) begin
      n_fail++;
      $display("FAIL sel6_range: got v=%0b e=%0b d=%0h, required v=0 e=1 d=6", valid6, err6, data6);
    end
    sel6 = 3'd2;
    tick();
    n_checks++;
    if ({valid6, err6, data6, ch6} !== {1'b1, 1'b0, 4'd5, 3'd2}) begin
      n_fail++;
      $display("FAIL sel6_recover: got v=%0b e=%0b d=%0h c=%0d, required v=1 e=0 d=5 c=2",
               valid6, err6, data6, ch6);
    end
  endtask

  task automatic test_scan();
    int got;
    int budget;
    int t_ref;
    mode8  = 1'b1;
    ch_en8 = 8'b1010_0100;
    dwell8 = 8'd3;
    tick();
    n_checks++;
    if ({valid8, busy8} !== 2'b00) begin
      n_fail++;
      $display("FAIL scan_mode_entry: got v=%0b b=%0b, required 0 0", valid8, busy8);
    end
    sb.push_back(mk(2));
    sb.push_back(mk(5));
    sb.push_back(mk(7));
    sb.push_back(mk(2));
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    t_ref  = cyc;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL scan_busy: got %0b, required 1", busy8);
    end
    got    = 0;
    budget = 0;
    while (got < 4 && budget < 100) begin
      if (valid8 && ready8) begin
        e = sb.pop_front();
        n_checks++;
        if ({ch8, data8} !== e) begin
          n_fail++;
          $display("FAIL scan_word: #%0d got ch=%0d d=%0h, required ch=%0d d=%0h",
                   got, ch8, data8, e.ch, e.data);
        end
        // dwell+1 edges from the start/accept edge to the rising out_valid
        n_checks++;
        if (cyc - t_ref != 4) begin
          n_fail++;
          $display("FAIL scan_gap: #%0d got %0d cycles, required 4", got, cyc - t_ref);
        end
        t_ref = cyc + 1;
        got++;
      end
      tick();
      budget++;
    end
    if (got < 4) begin
      n_checks++;
      n_fail++;
      $display("FAIL scan_timeout: got %0d words, required 4", got);
    end
  endtask

  task automatic test_backpressure();
    ready8 = 1'b0;
    sb.push_back(mk(5));
    sb.push_back(mk(7));
    wait_valid8(20);
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({valid8, ch8, data8} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d got v=%0b ch=%0d d=%0h, required v=1 ch=%0d d=%0h",
                 i, valid8, ch8, data8, e.ch, e.data);
      end
    end
    ready8 = 1'b1;
    e = sb.pop_front();
    n_checks++;
    if ({valid8, ch8, data8} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL bp_release: got ch=%0d d=%0h, required ch=%0d d=%0h", ch8, data8, e.ch, e.data);
    end
    tick();
    wait_valid8(20);
    e = sb.pop_front();
    n_checks++;
    if ({ch8, data8} !== e) begin
      n_fail++;
      $display("FAIL bp_next: got ch=%0d d=%0h, required ch=%0d d=%0h", ch8, data8, e.ch, e.data);
    end
    tick();
  endtask

  task automatic test_stop();
    sb.push_back(mk(2));
    sb.push_back(mk(5));
    wait_valid8(20);
    e = sb.pop_front();
    n_checks++;
    if ({ch8, data8} !== e) begin
      n_fail++;
      $display("FAIL stop_pre: got ch=%0d d=%0h, required ch=%0d d=%0h", ch8, data8, e.ch, e.data);
    end
    tick();
    stop8 = 1'b1;
    tick();
    stop8 = 1'b0;
    wait_valid8(20);
    e = sb.pop_front();
    n_checks++;
    if ({ch8, data8} !== e) begin
      n_fail++;
      $display("FAIL stop_inflight: got ch=%0d d=%0h, required ch=%0d d=%0h", ch8, data8, e.ch, e.data);
    end
    tick();
    n_checks++;
    if ({busy8, valid8} !== 2'b00) begin
      n_fail++;
      $display("FAIL stop_idle: got b=%0b v=%0b, required 0 0", busy8, valid8);
    end
    repeat (8) tick();
    n_checks++;
    if ({busy8, valid8} !== 2'b00) begin
      n_fail++;
      $display("FAIL stop_stays_idle: got b=%0b v=%0b, required 0 0", busy8, valid8);
    end
    ch_en8 = 8'd0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL start_no_ch: got busy=%0b, required 0", busy8);
    end
  endtask

  task automatic test_reset_mid();
    ch_en8 = 8'b1010_0100;
    ready8 = 1'b1;
    sb.push_back(mk(2));
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_valid8(20);
    e = sb.pop_front();
    n_checks++;
    if ({ch8, data8} !== e) begin
      n_fail++;
      $display("FAIL rm_first: got ch=%0d, required ch=%0d", ch8, e.ch);
    end
    tick();
    ready8 = 1'b0;
    wait_valid8(20);
    n_checks++;
    if (ch8 !== 3'd5) begin
      n_fail++;
      $display("FAIL rm_present: got ch=%0d, required 5", ch8);
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid8, busy8} !== 2'b00) begin
      n_fail++;
      $display("FAIL rm_async: got v=%0b b=%0b, required 0 0", valid8, busy8);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    ready8 = 1'b1;
    tick();
    sb.push_back(mk(2));
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_restart_busy: got %0b, required 1", busy8);
    end
    wait_valid8(20);
    e = sb.pop_front();
    n_checks++;
    if ({ch8, data8} !== e) begin
      n_fail++;
      $display("FAIL rm_restart: got ch=%0d d=%0h, required ch=%0d d=%0h", ch8, data8, e.ch, e.data);
    end
    tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    for (int k = 0; k < 8; k++) din8[k*4 +: 4] = 4'(k + 3);
    for (int k = 0; k < 6; k++) din6[k*4 +: 4] = 4'(k + 3);
    ch_en8 = 8'd0;  mode8 = 1'b0; sel8 = 3'd0; dwell8 = 8'd0;
    start8 = 1'b0;  stop8 = 1'b0; ready8 = 1'b0;
    ch_en6 = 6'd0;  mode6 = 1'b0; sel6 = 3'd0; dwell6 = 8'd0;
    start6 = 1'b0;  stop6 = 1'b0; ready6 = 1'b0;

    test_reset();
    test_fixed();
    test_sel_err();
    test_scan();
    test_backpressure();
    test_stop();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
